// File: rtl/vecmac_job_sched_if.sv
// Host job ports, operand memory ports, MAC beat/result ports and response port
// of the vecmac job scheduler, bundled into one interface.
interface vecmac_job_sched_if #(
  parameter int unsigned ADDR_W = 10
) ();

  // Requester 0 / 1 job ports
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_base_a;
  logic [ADDR_W-1:0] req0_base_b;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_base_a;
  logic [ADDR_W-1:0] req1_base_b;
  logic              req1_ready;

  // Operand memories (synchronous read, shared strobe)
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_a_addr;
  logic [ADDR_W-1:0] mem_b_addr;
  logic [31:0]       mem_a_rdata;
  logic [31:0]       mem_b_rdata;

  // MAC beat stream and result
  logic              vec_valid;
  logic [31:0]       vec_a;
  logic [31:0]       vec_b;
  logic              mac_result_valid;
  logic [31:0]       mac_result_sum;

  // Job response
  logic              rsp_valid;
  logic              rsp_id;
  logic              rsp_err;
  logic [31:0]       rsp_sum;
  logic              busy;

  // Scheduler side
  modport master (
    input  req0_valid, req0_base_a, req0_base_b,
    input  req1_valid, req1_base_a, req1_base_b,
    output req0_ready, req1_ready,
    output mem_rd_en, mem_a_addr, mem_b_addr,
    input  mem_a_rdata, mem_b_rdata,
    output vec_valid, vec_a, vec_b,
    input  mac_result_valid, mac_result_sum,
    output rsp_valid, rsp_id, rsp_err, rsp_sum, busy
  );

  // Environment side (requesters, memories, MAC)
  modport slave (
    output req0_valid, req0_base_a, req0_base_b,
    output req1_valid, req1_base_a, req1_base_b,
    input  req0_ready, req1_ready,
    input  mem_rd_en, mem_a_addr, mem_b_addr,
    output mem_a_rdata, mem_b_rdata,
    input  vec_valid, vec_a, vec_b,
    output mac_result_valid, mac_result_sum,
    input  rsp_valid, rsp_id, rsp_err, rsp_sum, busy
  );

endinterface

// File: rtl/vecmac_job_sched.sv
// Round-robin job scheduler in front of a shared vector MAC: fetches operand
// vectors, streams exactly BEATS beats, waits for the result (with timeout)
// and returns a one-cycle response to the granted requester.
module vecmac_job_sched #(
  parameter int unsigned ELEMS        = 1000,
  parameter int unsigned ACTIVE_LANES = 1,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned WAIT_MAX     = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  vecmac_job_sched_if.master bus
);

  localparam int unsigned BEATS = (ELEMS + ACTIVE_LANES - 1) / ACTIVE_LANES;
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
  localparam int unsigned WT_W  = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  // Only 1 or 4 int8 lanes per 32-bit beat are supported
  if (!(ACTIVE_LANES == 1 || ACTIVE_LANES == 4)) begin : g_lanes_chk
    $error("vecmac_job_sched: ACTIVE_LANES must be 1 or 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WAIT_RES,
    S_RESP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last, w_last_nxt;
  logic              r_id, w_id_nxt;
  logic [ADDR_W-1:0] r_base_a, w_base_a_nxt;
  logic [ADDR_W-1:0] r_base_b, w_base_b_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [WT_W-1:0]   r_wait, w_wait_nxt;
  logic              r_rd_en, w_rd_en_nxt;
  logic [ADDR_W-1:0] r_a_addr, w_a_addr_nxt;
  logic [ADDR_W-1:0] r_b_addr, w_b_addr_nxt;
  logic              r_vec_valid;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic              r_rsp_id, w_rsp_id_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic [31:0]       r_rsp_sum, w_rsp_sum_nxt;
  logic              r_busy, w_busy_nxt;

  logic              w_idle;
  logic              w_grant;
  logic              w_hs;
  logic [ADDR_W-1:0] w_sel_base_a;
  logic [ADDR_W-1:0] w_sel_base_b;
  logic [CNT_W-1:0]  w_cnt_inc;

  // Grant: on a tie the requester not served last wins, otherwise whoever asks
  always_comb begin
    w_idle       = (r_state == S_IDLE);
    w_grant      = bus.req1_valid & (~bus.req0_valid | ~r_last);
    w_hs         = w_idle & (w_grant ? bus.req1_valid : bus.req0_valid);
    w_sel_base_a = w_grant ? bus.req1_base_a : bus.req0_base_a;
    w_sel_base_b = w_grant ? bus.req1_base_b : bus.req0_base_b;
    w_cnt_inc    = r_cnt + CNT_W'(1);
  end

  assign bus.req0_ready = rst_n & w_idle & ~w_grant;
  assign bus.req1_ready = rst_n & w_idle &  w_grant;

  // Next-state and next-output logic; registered outputs are loaded from here
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_id_nxt        = r_id;
    w_base_a_nxt    = r_base_a;
    w_base_b_nxt    = r_base_b;
    w_cnt_nxt       = r_cnt;
    w_wait_nxt      = r_wait;
    w_rd_en_nxt     = 1'b0;
    w_a_addr_nxt    = r_a_addr;
    w_b_addr_nxt    = r_b_addr;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_sum_nxt   = r_rsp_sum;

    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_nxt  = S_ISSUE;
          w_id_nxt     = w_grant;
          w_base_a_nxt = w_sel_base_a;
          w_base_b_nxt = w_sel_base_b;
          w_cnt_nxt    = '0;
          w_rd_en_nxt  = 1'b1;
          w_a_addr_nxt = w_sel_base_a;
          w_b_addr_nxt = w_sel_base_b;
        end
      end

      S_ISSUE: begin
        // r_cnt is the beat whose address is on the bus this cycle
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == CNT_W'(BEATS - 1)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_en_nxt  = 1'b1;
          w_a_addr_nxt = r_base_a + ADDR_W'(w_cnt_inc);
          w_b_addr_nxt = r_base_b + ADDR_W'(w_cnt_inc);
        end
      end

      S_DRAIN: begin
        w_wait_nxt = '0;
        if (bus.mac_result_valid) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_id;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_sum_nxt   = bus.mac_result_sum;
        end else begin
          w_state_nxt = S_WAIT_RES;
        end
      end

      S_WAIT_RES: begin
        if (bus.mac_result_valid) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_id;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_sum_nxt   = bus.mac_result_sum;
        end else if (r_wait == WT_W'(WAIT_MAX - 1)) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_id_nxt    = r_id;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_sum_nxt   = '0;
        end else begin
          w_wait_nxt = r_wait + WT_W'(1);
        end
      end

      S_RESP: begin
        w_last_nxt  = r_id;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and registered outputs; reset leaves "last served = 1" so req0 wins first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_rd_en     <= 1'b0;
      r_a_addr    <= '0;
      r_b_addr    <= '0;
      r_vec_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_sum   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_id        <= w_id_nxt;
      r_base_a    <= w_base_a_nxt;
      r_base_b    <= w_base_b_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wait      <= w_wait_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_a_addr    <= w_a_addr_nxt;
      r_b_addr    <= w_b_addr_nxt;
      r_vec_valid <= r_rd_en;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_sum   <= w_rsp_sum_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.mem_rd_en  = r_rd_en;
  assign bus.mem_a_addr = r_a_addr;
  assign bus.mem_b_addr = r_b_addr;
  assign bus.vec_valid  = r_vec_valid;
  // Memory data passes straight through, held at 0 outside valid beats
  assign bus.vec_a      = r_vec_valid ? bus.mem_a_rdata : 32'h0;
  assign bus.vec_b      = r_vec_valid ? bus.mem_b_rdata : 32'h0;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.rsp_sum    = r_rsp_sum;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_vecmac_job_sched.sv
// Bench for vecmac_job_sched: one-lane instance checked every cycle against a
// job-level model, plus a four-lane instance checked on its response.
module tb_vecmac_job_sched;

  localparam int B0 = 8;   // beats of the one-lane instance
  localparam int WM = 5;   // WAIT_MAX of both instances
  localparam int B1 = 2;   // beats of the four-lane instance

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vecmac_job_sched_if #(.ADDR_W(4)) b0 ();
  vecmac_job_sched_if #(.ADDR_W(4)) b1 ();

  vecmac_job_sched #(.ELEMS(8), .ACTIVE_LANES(1), .ADDR_W(4), .WAIT_MAX(WM)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  vecmac_job_sched #(.ELEMS(8), .ACTIVE_LANES(4), .ADDR_W(4), .WAIT_MAX(WM)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  // Operand memories with one-cycle read latency
  logic [31:0] mem0_a [16];
  logic [31:0] mem0_b [16];
  logic [31:0] mem1_a [16];
  logic [31:0] mem1_b [16];

  always @(posedge clk) begin
    if (b0.mem_rd_en) begin
      b0.mem_a_rdata <= mem0_a[b0.mem_a_addr];
      b0.mem_b_rdata <= mem0_b[b0.mem_b_addr];
    end
    if (b1.mem_rd_en) begin
      b1.mem_a_rdata <= mem1_a[b1.mem_a_addr];
      b1.mem_b_rdata <= mem1_b[b1.mem_b_addr];
    end
  end

  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b, input int lanes);
    int s = 0;
    for (int l = 0; l < lanes; l++) s += $signed(a[8*l +: 8]) * $signed(b[8*l +: 8]);
    return 32'(s);
  endfunction

  // MAC stubs: accumulate a job's beats, present the sum one cycle after the last beat
  int          nb0, nb1;
  logic [31:0] acc0, acc1, mac0_sum, mac1_sum;
  logic        mac0_rv, mac1_rv, mac0_en, stray0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nb0 <= 0; acc0 <= 0; mac0_rv <= 0; mac0_sum <= 0;
      nb1 <= 0; acc1 <= 0; mac1_rv <= 0; mac1_sum <= 0;
    end else begin
      mac0_rv <= 0;
      mac1_rv <= 0;
      if (b0.vec_valid) begin
        if (nb0 == B0 - 1) begin
          nb0 <= 0; acc0 <= 0;
          if (mac0_en) begin mac0_rv <= 1; mac0_sum <= acc0 + dot(b0.vec_a, b0.vec_b, 1); end
        end else begin
          nb0 <= nb0 + 1; acc0 <= acc0 + dot(b0.vec_a, b0.vec_b, 1);
        end
      end
      if (b1.vec_valid) begin
        if (nb1 == B1 - 1) begin
          nb1 <= 0; acc1 <= 0; mac1_rv <= 1; mac1_sum <= acc1 + dot(b1.vec_a, b1.vec_b, 4);
        end else begin
          nb1 <= nb1 + 1; acc1 <= acc1 + dot(b1.vec_a, b1.vec_b, 4);
        end
      end
    end
  end

  assign b0.mac_result_valid = mac0_rv | stray0;
  assign b0.mac_result_sum   = stray0 ? 32'h0BAD_0BAD : mac0_sum;
  assign b1.mac_result_valid = mac1_rv;
  assign b1.mac_result_sum   = mac1_sum;

  // Hand-computed expectations consumed by the compare process
  typedef struct { int id; int err; int sum; int lat; } lit_t;
  lit_t lit0_q[$];
  lit_t lit1_q[$];
  int   lita_q[$];

  int  checks = 0, errs = 0, cyc = 0;
  int  rsp0_cnt = 0, rsp1_cnt = 0;
  int  wait_expired = 0, wait_seen = 0;
  bit  done = 0, done_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Job-level model of the one-lane instance: cycle k counts from the handshake
  bit          m_act, m_id, m_res, m_err, m_last, g;
  int          m_k, m_rk;
  logic [3:0]  m_ba, m_bb, ea, eb;
  logic [31:0] m_sum;
  bit          e_rd, e_vv, e_busy, e_rsp;
  lit_t        lt;
  int          beats1, hs1;
  bit          hs1_seen;

  always @(negedge clk) begin
    cyc++;
    if (wait_expired != wait_seen) begin
      chk("wait_bound", 32'(wait_expired), 32'(wait_seen));
      wait_seen = wait_expired;
    end
    if (!rst_n) begin
      m_act = 0; m_last = 1; beats1 = 0; hs1_seen = 0;
      chk("rst_rd_en", b0.mem_rd_en, 0);
      chk("rst_vec_valid", b0.vec_valid, 0);
      chk("rst_rsp_valid", b0.rsp_valid, 0);
      chk("rst_rsp_err", b0.rsp_err, 0);
      chk("rst_busy", b0.busy, 0);
      chk("rst_ready", {b0.req1_ready, b0.req0_ready}, 0);
      chk("rst_addr", {b0.mem_a_addr, b0.mem_b_addr}, 0);
      chk("rst_rsp_sum", b0.rsp_sum, 0);
      chk("rst_vec_a", b0.vec_a, 0);
    end else begin
      if (m_act) m_k++;
      if (m_act && m_res && m_k > m_rk) m_act = 0;
      e_rd   = m_act && m_k >= 1 && m_k <= B0;
      e_vv   = m_act && m_k >= 2 && m_k <= B0 + 1;
      e_busy = m_act && m_k >= 1;
      e_rsp  = m_act && m_res && m_k == m_rk;

      chk("mem_rd_en", b0.mem_rd_en, e_rd);
      if (e_rd) begin
        ea = m_ba + 4'(m_k - 1);
        eb = m_bb + 4'(m_k - 1);
        chk("mem_a_addr", b0.mem_a_addr, ea);
        chk("mem_b_addr", b0.mem_b_addr, eb);
        if (lita_q.size() > 0) chk("addr_literal", b0.mem_a_addr, 32'(lita_q.pop_front()));
      end
      chk("vec_valid", b0.vec_valid, e_vv);
      if (e_vv) begin
        ea = m_ba + 4'(m_k - 2);
        eb = m_bb + 4'(m_k - 2);
        chk("vec_a", b0.vec_a, mem0_a[ea]);
        chk("vec_b", b0.vec_b, mem0_b[eb]);
      end
      chk("busy", b0.busy, e_busy);
      chk("rsp_valid", b0.rsp_valid, e_rsp);
      if (e_rsp) begin
        chk("rsp_id", b0.rsp_id, m_id);
        chk("rsp_err", b0.rsp_err, m_err);
        chk("rsp_sum", b0.rsp_sum, m_sum);
        if (lit0_q.size() > 0) begin
          lt = lit0_q.pop_front();
          chk("lit_id", b0.rsp_id, 32'(lt.id));
          chk("lit_err", b0.rsp_err, 32'(lt.err));
          chk("lit_sum", b0.rsp_sum, 32'(lt.sum));
          chk("lit_latency", 32'(m_k), 32'(lt.lat));
        end
        m_last = m_id;
        rsp0_cnt++;
      end

      g = b0.req1_valid && (!b0.req0_valid || !m_last);
      if (m_act) begin
        chk("ready_busy", {b0.req1_ready, b0.req0_ready}, 0);
      end else if (b0.req0_valid || b0.req1_valid) begin
        chk("ready_grant", {b0.req1_ready, b0.req0_ready}, g ? 2 : 1);
      end

      if (m_act && !m_res && m_k >= B0 + 1) begin
        if (b0.mac_result_valid) begin
          m_res = 1; m_rk = m_k + 1; m_err = 0; m_sum = b0.mac_result_sum;
        end else if (m_k == B0 + 1 + WM) begin
          m_res = 1; m_rk = m_k + 1; m_err = 1; m_sum = 0;
        end
      end

      if (!m_act && (b0.req0_valid || b0.req1_valid)) begin
        m_act = 1; m_k = 0; m_id = g; m_res = 0;
        m_ba = g ? b0.req1_base_a : b0.req0_base_a;
        m_bb = g ? b0.req1_base_b : b0.req0_base_b;
      end

      // Four-lane instance: beat count and response against literals
      if (b1.req0_valid && !hs1_seen) begin hs1 = cyc; hs1_seen = 1; end
      if (b1.vec_valid) beats1++;
      if (b1.rsp_valid) begin
        chk("lanes4_beats", 32'(beats1), 32'(B1));
        chk("lanes4_unexpected_rsp", 32'(lit1_q.size() > 0), 1);
        if (lit1_q.size() > 0) begin
          lt = lit1_q.pop_front();
          chk("lanes4_id", b1.rsp_id, 32'(lt.id));
          chk("lanes4_err", b1.rsp_err, 32'(lt.err));
          chk("lanes4_sum", b1.rsp_sum, 32'(lt.sum));
          chk("lanes4_latency", 32'(cyc - hs1), 32'(lt.lat));
        end
        beats1 = 0; hs1_seen = 0;
        rsp1_cnt++;
      end
    end
    if (done && !done_chk) begin
      chk("lit0_pending", 32'(lit0_q.size()), 0);
      chk("lit1_pending", 32'(lit1_q.size()), 0);
      chk("addr_pending", 32'(lita_q.size()), 0);
      done_chk = 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a job on instance u, requester r, until it is accepted
  task automatic job(input int u, input int r, input logic [3:0] ba, input logic [3:0] bb);
    bit hs = 0;
    if (u == 0) begin
      if (r == 0) begin b0.req0_valid = 1; b0.req0_base_a = ba; b0.req0_base_b = bb; end
      else        begin b0.req1_valid = 1; b0.req1_base_a = ba; b0.req1_base_b = bb; end
    end else begin
      b1.req0_valid = 1; b1.req0_base_a = ba; b1.req0_base_b = bb;
    end
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = (u == 0) ? ((r == 0) ? b0.req0_ready : b0.req1_ready) : b1.req0_ready;
      @(posedge clk); #1;
    end
    if (!hs) begin $display("FAIL handshake: no ready within 50 cycles"); wait_expired++; end
    b0.req0_valid = 0; b0.req1_valid = 0; b1.req0_valid = 0;
  endtask

  task automatic wait_rsp(input int u, input int target);
    bit ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(posedge clk); #1;
      ok = ((u == 0) ? rsp0_cnt : rsp1_cnt) >= target;
    end
    if (!ok) begin $display("FAIL response_wait: count target %0d not reached", target); wait_expired++; end
  endtask

  task automatic do_reset();
    rst_n = 0;
    cycles(2);
    rst_n = 1;
    cycles(1);
  endtask

  initial begin
    rst_n = 0;
    mac0_en = 1; stray0 = 0;
    b0.req0_valid = 0; b0.req1_valid = 0; b1.req0_valid = 0; b1.req1_valid = 0;
    b0.req0_base_a = 0; b0.req0_base_b = 0; b0.req1_base_a = 0; b0.req1_base_b = 0;
    b1.req0_base_a = 0; b1.req0_base_b = 0; b1.req1_base_a = 0; b1.req1_base_b = 0;
    for (int i = 0; i < 16; i++) begin
      mem0_a[i] = 32'(i + 1);
      mem0_b[i] = 32'd2;
      mem1_a[i] = 32'h0403_0201;
      mem1_b[i] = 32'h0101_0101;
    end
    cycles(3);
    rst_n = 1;
    cycles(2);

    // Single job: 2*(1+..+8) = 72, response 11 cycles after handshake
    lit0_q.push_back('{0, 0, 72, 11});
    job(0, 0, 4'd0, 4'd8);
    wait_rsp(0, 1);
    cycles(2);

    // Address wrap: a words at 14,15,0..5 = 15,16,1..6 -> 2*52 = 104
    lit0_q.push_back('{0, 0, 104, 11});
    foreach (lita_q[i]) lita_q.delete(i);
    lita_q = '{14, 15, 0, 1, 2, 3, 4, 5};
    job(0, 0, 4'd14, 4'd0);
    wait_rsp(0, 2);
    cycles(2);

    // Simultaneous held requests straight out of reset: order 0,1,0,1
    do_reset();
    lit0_q.push_back('{0, 0, 72, 11});
    lit0_q.push_back('{1, 0, 136, 11});
    lit0_q.push_back('{0, 0, 72, 11});
    lit0_q.push_back('{1, 0, 136, 11});
    b0.req0_valid = 1; b0.req0_base_a = 4'd0; b0.req0_base_b = 4'd8;
    b0.req1_valid = 1; b0.req1_base_a = 4'd4; b0.req1_base_b = 4'd0;
    wait_rsp(0, rsp0_cnt + 4);
    b0.req0_valid = 0; b0.req1_valid = 0;
    cycles(3);

    // Timeout: no MAC result, error response at BEATS+7, stray result ignored
    mac0_en = 0;
    lit0_q.push_back('{0, 1, 0, B0 + 2 + WM});
    job(0, 0, 4'd0, 4'd8);
    wait_rsp(0, rsp0_cnt + 1);
    cycles(1);
    stray0 = 1;
    cycles(1);
    stray0 = 0;
    cycles(4);
    mac0_en = 1;

    // Reset during the third ISSUE beat, then a clean job: 2*(5+..+12) = 136
    job(0, 0, 4'd0, 4'd8);
    cycles(2);
    rst_n = 0;
    cycles(2);
    rst_n = 1;
    cycles(2);
    lit0_q.push_back('{0, 0, 136, 11});
    job(0, 0, 4'd4, 4'd0);
    wait_rsp(0, rsp0_cnt + 1);
    cycles(2);

    // Four-lane packing: 2 beats of {4,3,2,1}.{1,1,1,1} = 20
    lit1_q.push_back('{0, 0, 20, B1 + 3});
    job(1, 0, 4'd0, 4'd0);
    wait_rsp(1, 1);
    cycles(3);

    done = 1;
    cycles(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/vecmac_job_sched.md
# vecmac_job_sched

Job scheduler that shares one `vector_mac_top_param` instance between two requesters. It arbitrates round-robin between the requesters and fetches both operand vectors from two synchronous-read memories. It streams the fetched words into the MAC as exactly BEATS valid beats, waits for the MAC result, and returns the result (or a timeout error) to the granted requester. It sits between the host-side job ports and the MAC datapath, and is the only driver of the MAC's `vec_*` inputs.

## Interface
- ELEMS, 1000: vector length in int8 elements; must match the MAC instance.
- ACTIVE_LANES, 1: elements per 32-bit beat; legal values 1 or 4, any other value is an elaboration error.
- ADDR_W, 10: word-address width of both operand memories.
- WAIT_MAX, 64: maximum cycles spent in WAIT_RES before a timeout.
- Derived: BEATS = (ELEMS+ACTIVE_LANES-1)/ACTIVE_LANES; beat counter width $clog2(BEATS+1).
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid, req1_valid  in  1  job request from requester 0 / 1.
- req0_base_a, req1_base_a  in  ADDR_W  start word address of vector A.
- req0_base_b, req1_base_b  in  ADDR_W  start word address of vector B.
- req0_ready, req1_ready  out  1  request accepted this cycle when high together with valid.
- mem_rd_en  out  1  read strobe shared by both memories.
- mem_a_addr, mem_b_addr  out  ADDR_W  read addresses.
- mem_a_rdata, mem_b_rdata  in  32  read data, valid one cycle after mem_rd_en.
- vec_valid  out  1  beat valid to the MAC.
- vec_a, vec_b  out  32  beat operands to the MAC.
- mac_result_valid  in  1  MAC result strobe.
- mac_result_sum  in  32  MAC result.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester the response belongs to.
- rsp_err  out  1  1 = timeout; rsp_sum is 0 in that case.
- rsp_sum  out  32  dot-product result.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, WAIT_RES, RESP.
- **IDLE**
  - Grant selection:
    - Both requesters valid: grant goes to the requester not served last.
    - One requester valid: that requester is granted.
  - reqN_ready = (state==IDLE) && grant==N. It is combinational, and at most one ready is high.
  - On handshake, latch base_a, base_b and id, clear the beat counter, and go to ISSUE.
- **ISSUE**
  - mem_rd_en=1; mem_a_addr = base_a + cnt, mem_b_addr = base_b + cnt.
  - Addresses wrap modulo 2^ADDR_W.
  - cnt increments each cycle. After the beat with cnt==BEATS-1, go to DRAIN.
- **Beat delivery**
  - vec_valid is mem_rd_en delayed one cycle (registered).
  - vec_a/vec_b = mem_a_rdata/mem_b_rdata, passed straight through.
  - vec_valid is never high outside the cycle after an ISSUE cycle. Exactly BEATS beats are produced per job.
- **DRAIN**: one cycle, carrying the last beat; then go to WAIT_RES.
- **WAIT_RES**
  - Timeout counter starts at 0 and increments each cycle.
  - mac_result_valid in DRAIN or WAIT_RES:
    - capture mac_result_sum;
    - rsp_err=0;
    - go to RESP.
  - Counter reaching WAIT_MAX without a result:
    - rsp_err=1;
    - captured sum forced to 0;
    - go to RESP.
- **RESP**
  - rsp_valid=1 for exactly one cycle, with rsp_id, rsp_err and rsp_sum.
  - Update the round-robin pointer to "last served = id".
  - Go to IDLE.
- mac_result_valid in IDLE, ISSUE or RESP is ignored. A late result after a timeout does not generate a response.
- A request deasserted before its handshake is simply not served. No request is queued internally.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; round-robin pointer = "last served 1", so requester 0 wins the first tie.
  - All counters 0.
  - mem_rd_en, vec_valid, rsp_valid, rsp_err, busy = 0.
  - All address, data and sum outputs = 0.
  - reqN_ready follows IDLE rules once reset is released.
- Reset mid-job: the job is abandoned with no response. The MAC shares rst_n, so its accumulator restarts cleanly.
- Cycle numbering, with the handshake at cycle 0:
  - ISSUE runs cycles 1..BEATS.
  - vec_valid is high in cycles 2..BEATS+1.
  - DRAIN is cycle BEATS+1.
  - A result captured at cycle R gives rsp_valid at R+1.
  - The next handshake is possible at R+2.
- Timeout response: rsp_valid at cycle BEATS+2+WAIT_MAX.
- Back-to-back jobs must never overlap beats. The MAC sees a gap of at least 3 idle cycles between jobs.

## Test plan
- **Single job** (ELEMS=8, ACTIVE_LANES=1, requester 0)
  - Stimulus: a[i]=i+1, b[i]=2, base_a=0, base_b=16.
  - Response: 8 beats on vec_valid, in address order; rsp_valid with id=0, err=0, sum=72.
- **Four-lane packing** (ELEMS=8, ACTIVE_LANES=4)
  - Stimulus: each memory word holds {4,3,2,1} and {1,1,1,1}.
  - Response: exactly 2 beats; sum=20.
- **Simultaneous requests**
  - Stimulus: req0 and req1 valid together, held valid, out of reset.
  - Response: grant order 0,1,0,1; no overlapping vec_valid bursts; rsp_id alternates.
- **Address wrap** (ADDR_W=4)
  - Stimulus: base_a=14, ELEMS=4.
  - Response: mem_a_addr sequence is 14,15,0,1.
- **Timeout** (WAIT_MAX=5)
  - Stimulus: MAC stubbed so it never asserts mac_result_valid.
  - Response: rsp_err=1 and sum=0 at cycle BEATS+7; a later stray mac_result_valid produces no rsp_valid.
- **Reset mid-ISSUE**
  - Stimulus: rst_n pulled low at beat 3.
  - Response: all outputs 0 immediately and no response for the abandoned job; the next job yields a correct sum.
